// File: rtl/lcd_write_arbiter.sv
// Two-requester write arbiter for an HD44780-style character LCD.
// Captures one byte per transfer and sequences RS/data setup, enable pulse and settle wait.
module lcd_write_arbiter #(
  parameter int unsigned T_SETUP = 50,
  parameter int unsigned T_PULSE = 25,
  parameter int unsigned T_WAIT  = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rs0,
  input  logic       rs1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       lock0,
  input  logic       lock1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy,
  output logic       owner
);

  localparam int unsigned MaxA = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned MaxB = (T_WAIT > T_CLEAR) ? T_WAIT : T_CLEAR;
  localparam int unsigned MaxT = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW = (MaxT > 1) ? $clog2(MaxT + 1) : 1;

  localparam logic [CntW-1:0] SetupLast = CntW'(T_SETUP - 1);
  localparam logic [CntW-1:0] PulseLast = CntW'(T_PULSE - 1);
  localparam logic [CntW-1:0] WaitLast  = CntW'(T_WAIT - 1);
  localparam logic [CntW-1:0] ClearLast = CntW'(T_CLEAR - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StPulse,
    StWait
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [CntW-1:0] w_wait_last;

  logic [7:0] r_lcd_data;
  logic       r_lcd_rs;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_owner;
  logic       r_lock;
  logic       r_clear;

  logic       w_grant_valid;
  logic       w_grant;
  logic       w_capture;
  logic       w_sel_rs;
  logic [7:0] w_sel_data;
  logic       w_sel_lock;
  logic       w_sel_clear;

  // While locked the owner keeps the bus even when it has nothing pending.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = r_owner;
    if (r_lock) begin
      w_grant_valid = r_owner ? req1 : req0;
    end else if (req0 && req1) begin
      w_grant_valid = 1'b1;
      w_grant       = ~r_owner;
    end else if (req0) begin
      w_grant_valid = 1'b1;
      w_grant       = 1'b0;
    end else if (req1) begin
      w_grant_valid = 1'b1;
      w_grant       = 1'b1;
    end
  end

  assign w_sel_rs    = w_grant ? rs1 : rs0;
  assign w_sel_data  = w_grant ? data1 : data0;
  assign w_sel_lock  = w_grant ? lock1 : lock0;
  assign w_sel_clear = !w_sel_rs && ((w_sel_data == 8'h01) || (w_sel_data == 8'h02));

  assign w_wait_last = r_clear ? ClearLast : WaitLast;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant_valid) begin
          w_capture    = 1'b1;
          w_state_next = StSetup;
          w_cnt_next   = '0;
        end
      end
      StSetup: begin
        if (r_cnt == SetupLast) begin
          w_state_next = StPulse;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      StPulse: begin
        if (r_cnt == PulseLast) begin
          w_state_next = StWait;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      StWait: begin
        if (r_cnt == w_wait_last) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  // owner resets to 1 so that requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_lcd_data <= 8'h00;
      r_lcd_rs   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_owner    <= 1'b1;
      r_lock     <= 1'b0;
      r_clear    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ack0  <= w_capture && !w_grant;
      r_ack1  <= w_capture && w_grant;
      if (w_capture) begin
        r_lcd_data <= w_sel_data;
        r_lcd_rs   <= w_sel_rs;
        r_owner    <= w_grant;
        r_lock     <= w_sel_lock;
        r_clear    <= w_sel_clear;
      end
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign lcd_data = r_lcd_data;
  assign lcd_rs   = r_lcd_rs;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = (r_state == StPulse);
  assign busy     = (r_state != StIdle);
  assign owner    = r_owner;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transfer-age reference model.
module tb_lcd_write_arbiter;

  localparam int unsigned TS = 2;
  localparam int unsigned TP = 3;
  localparam int unsigned TW = 4;
  localparam int unsigned TC = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       rs0 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       lock0 = 1'b0, lock1 = 1'b0;
  logic       ack0, ack1, lcd_rs, lcd_rw, lcd_en, busy, owner;
  logic [7:0] lcd_data;

  always #5 clock = ~clock;

  lcd_write_arbiter #(
    .T_SETUP(TS),
    .T_PULSE(TP),
    .T_WAIT (TW),
    .T_CLEAR(TC)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .rs0     (rs0),
    .rs1     (rs1),
    .data0   (data0),
    .data1   (data1),
    .lock0   (lock0),
    .lock1   (lock1),
    .ack0    (ack0),
    .ack1    (ack1),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en),
    .busy    (busy),
    .owner   (owner)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a transfer is "age" cycles old (0 = idle); its length is fixed at capture.
  int         m_age = 0;
  int         m_len = 0;
  logic       m_owner = 1'b1, m_lock = 1'b0, m_rs = 1'b0, m_ack0 = 1'b0, m_ack1 = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;

  always @(posedge clock) begin
    int         g;
    logic       g_rs, g_lock;
    logic [7:0] g_data;
    if (reset) begin
      m_age = 0; m_len = 0; m_owner = 1'b1; m_lock = 1'b0; m_rs = 1'b0; m_data = 8'h00;
      m_ack0 = 1'b0; m_ack1 = 1'b0; m_valid = 1'b1;
    end else begin
      m_ack0 = 1'b0;
      m_ack1 = 1'b0;
      if (m_age == 0) begin
        g = -1;
        if (m_lock) begin
          if (m_owner ? req1 : req0) g = int'(m_owner);
        end else if (req0 && req1) g = m_owner ? 0 : 1;
        else if (req0) g = 0;
        else if (req1) g = 1;
        if (g >= 0) begin
          g_rs   = (g == 1) ? rs1 : rs0;
          g_data = (g == 1) ? data1 : data0;
          g_lock = (g == 1) ? lock1 : lock0;
          m_rs = g_rs; m_data = g_data; m_lock = g_lock; m_owner = (g == 1);
          m_len = TS + TP + ((!g_rs && (g_data == 8'h01 || g_data == 8'h02)) ? TC : TW);
          m_age = 1;
          if (g == 1) m_ack1 = 1'b1; else m_ack0 = 1'b1;
        end
      end else if (m_age == m_len) begin
        m_age = 0;
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge clock) begin
    logic [14:0] act, exp;
    logic        m_en;
    if (m_valid) begin
      m_en = (m_age > TS) && (m_age <= TS + TP);
      exp  = {m_ack0, m_ack1, m_en, (m_age != 0), m_rs, 1'b0, m_owner, m_data};
      act  = {ack0, ack1, lcd_en, busy, lcd_rs, lcd_rw, owner, lcd_data};
      chk($sformatf("outputs vs model @%0t", $time), 32'(act), 32'(exp));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_any(input int budget, output int who, output int cyc);
    who = -1;
    cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      step();
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        who = (ack1 === 1'b1) ? 1 : 0;
        cyc = c;
        break;
      end
    end
  endtask

  task automatic measure(output int busy_n, output int en_n, output int first_en);
    busy_n = 0; en_n = 0; first_en = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy === 1'b1) busy_n++;
      if (lcd_en === 1'b1) begin
        en_n++;
        if (first_en == 0) first_en = i;
      end
      step();
    end
  endtask

  task automatic write0(input string name, input logic rs, input logic [7:0] d);
    req0 = 1'b1; rs0 = rs; data0 = d; lock0 = 1'b0;
    step();
    chk({name, " ack0"}, ack0, 1'b1);
    chk({name, " lcd_data"}, lcd_data, d);
    req0 = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic new_byte(output logic rs, output logic [7:0] d, output logic lk);
    if ($urandom_range(0, 3) == 0) begin
      rs = 1'b0;
      d  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
    end else begin
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
    end
    lk = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    int   bn, en, fe, who, cyc;
    int   ack_who[$];
    int   ack_at[$];
    logic p0, p1;

    repeat (2) step();
    reset = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset owner", owner, 1'b1);
    chk("reset lcd_data", lcd_data, 8'h00);
    chk("reset lcd_en", lcd_en, 1'b0);
    chk("reset acks", {ack0, ack1}, 2'b00);

    // Single character write
    write0("single", 1'b1, 8'h41);
    chk("single ack1", ack1, 1'b0);
    measure(bn, en, fe);
    chk("single busy cycles", bn, 9);
    chk("single en cycles", en, 3);
    chk("single en start", fe, 3);

    // Tie straight after reset alternates starting with requester 0
    pulse_reset();
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h30;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h31;
    for (int c = 1; c <= 60 && ack_who.size() < 4; c++) begin
      step();
      if (ack0 === 1'b1) begin ack_who.push_back(0); ack_at.push_back(c); end
      if (ack1 === 1'b1) begin ack_who.push_back(1); ack_at.push_back(c); end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie ack count", ack_who.size(), 4);
    for (int k = 0; k < ack_who.size(); k++) begin
      chk($sformatf("tie order %0d", k), ack_who[k], k % 2);
      if (k > 0) chk($sformatf("tie spacing %0d", k), ack_at[k] - ack_at[k-1], 10);
    end
    repeat (12) step();

    // Lock holds the bus for requester 0 even while its req is low
    pulse_reset();
    req0 = 1'b1; lock0 = 1'b1; rs0 = 1'b0; data0 = 8'h80;
    req1 = 1'b1; lock1 = 1'b0; rs1 = 1'b1; data1 = 8'h61;
    wait_any(5, who, cyc);
    chk("lock first grant", who, 0);
    chk("lock first data", lcd_data, 8'h80);
    req0 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("lock blocks req1", ack1, 1'b0);
    end
    req0 = 1'b1; lock0 = 1'b0; rs0 = 1'b1; data0 = 8'h48;
    wait_any(5, who, cyc);
    chk("lock second grant", who, 0);
    chk("lock second data", lcd_data, 8'h48);
    req0 = 1'b0;
    wait_any(15, who, cyc);
    chk("unlock grant", who, 1);
    chk("unlock data", lcd_data, 8'h61);
    req1 = 1'b0;
    repeat (12) step();

    // Clear/home use the long wait; rs=1 with the same byte does not
    write0("clear", 1'b0, 8'h01);
    measure(bn, en, fe);
    chk("clear busy cycles", bn, 15);
    chk("clear en cycles", en, 3);
    write0("home", 1'b0, 8'h02);
    measure(bn, en, fe);
    chk("home busy cycles", bn, 15);
    write0("char 01", 1'b1, 8'h01);
    measure(bn, en, fe);
    chk("char 01 busy cycles", bn, 9);

    // Reset during the enable pulse
    write0("pre-reset", 1'b1, 8'h55);
    step(); step();
    chk("in pulse", lcd_en, 1'b1);
    reset = 1'b1;
    step();
    chk("reset en", lcd_en, 1'b0);
    chk("reset busy mid", busy, 1'b0);
    chk("reset no ack", {ack0, ack1}, 2'b00);
    reset = 1'b0;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'h66;
    step();
    chk("post-reset ack1", ack1, 1'b1);
    chk("post-reset data", lcd_data, 8'h66);
    req1 = 1'b0;
    repeat (12) step();

    // Requester inputs moving while busy leave the bus untouched
    write0("hold", 1'b1, 8'h41);
    for (int i = 1; i <= 9; i++) begin
      data0 = 8'($urandom);
      rs0 = 1'($urandom_range(0, 1));
      if (i < 5) begin
        data1 = 8'($urandom);
        rs1 = 1'($urandom_range(0, 1));
      end else begin
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h77;
      end
      chk("hold lcd_data", lcd_data, 8'h41);
      chk("hold lcd_rs", lcd_rs, 1'b1);
      step();
    end
    wait_any(3, who, cyc);
    chk("late req1 grant", who, 1);
    chk("late req1 data", lcd_data, 8'h77);
    req1 = 1'b0;
    repeat (12) step();

    // Random traffic against the model
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if (p0 && m_ack0) begin p0 = 1'b0; req0 = 1'b0; end
      if (p1 && m_ack1) begin p1 = 1'b0; req1 = 1'b0; end
      if (!p0) begin
        new_byte(rs0, data0, lock0);
        if ($urandom_range(0, 7) == 0) begin p0 = 1'b1; req0 = 1'b1; end
      end
      if (!p1) begin
        new_byte(rs1, data1, lock1);
        if ($urandom_range(0, 7) == 0) begin p1 = 1'b1; req1 = 1'b1; end
      end
      step();
    end
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
